dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester controller sitting in front of the block-RAM data memory.
- Port 0 is the CPU load/store unit; port 1 is the DMA/program-loader port.
- Grants at most one access per cycle and drives the memory's wmem/rmem/address/store-data inputs.
- Tracks the memory's one-cycle registered read latency, so the rmem byte-select code is presented in the data phase and load data is routed back to the requester that issued the read.

Parameters:
- ADDR_W, 15, word-address width of the data memory; upper request address bits are ignored.
- MAX_WAIT, 8, consecutive denied cycles before port 1 is force-granted (starvation guard only).
- CNT_W, 4, width of the starvation counter; must satisfy 2**CNT_W > MAX_WAIT.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  port 0 request valid
- req0_wmem  in  4  store byte-lane code (0001/0010/0100/1000/0011/1100/1111, 0000 = no store)
- req0_rmem  in  5  load code ([4] = sign-extend, [3:0] = lanes, 00000 = no load)
- req0_addr  in  32  word address
- req0_wdata  in  32  store data, right-aligned
- req0_ready  out  1  request accepted this cycle
- rsp0_valid  out  1  load data valid
- rsp0_rdata  out  32  load data
- req1_valid, req1_wmem, req1_rmem, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata: same as port 0
- mem_wmem  out  4  to memory wmem
- mem_rmem  out  5  to memory rmem (data-phase code)
- mem_addr  out  32  to memory address, {zeros, addr[ADDR_W-1:0]}
- mem_store_data  out  32  to memory store data
- mem_load_data  in  32  from memory load data
- conflict_err  out  1  sticky; set on any accepted request with wmem!=0 and rmem!=0

Behaviour:
- Reset values:
  - All registered state clears: rd_pend = 0, rd_port = 0, rmem_q = 0, wait_cnt = 0, conflict_err = 0.
  - All outputs read 0.
- Handshake:
  - A request is accepted in a cycle where reqN_valid = 1 and it is granted.
  - reqN_ready = reqN_valid & grantN, combinational.
  - The requester holds all request fields stable until it sees ready.
  - reqN_valid must not depend on ready.
- Arbitration (default build): strict priority, port 0 over port 1. At most one grant per cycle.
- Address phase (cycle of acceptance):
  - mem_addr = granted address (low ADDR_W bits, zero-extended).
  - mem_wmem = granted wmem.
  - mem_store_data = granted wdata.
  - With no grant, mem_wmem = 0 and mem_addr holds its last value (registered hold, no glitching requirement).
- Data phase (cycle N+1 after a read accepted in cycle N, rmem!=0):
  - rd_pend = 1, rd_port = granted port, rmem_q = granted rmem.
  - mem_rmem = rmem_q.
  - rspP_valid = 1 for the port that issued the read, with rspP_rdata = mem_load_data.
  - The other port sees rsp valid = 0 and rdata = 0.
  - With rd_pend = 0, mem_rmem = 0.
- Latency and throughput:
  - Load latency is exactly 1 cycle after ready.
  - Back-to-back reads are fully pipelined: 1 read per cycle, either port.
- Store completion: a store is complete at the clock edge of acceptance. There is no store response.
- Illegal combination (wmem!=0 and rmem!=0):
  - The store is performed, the load is dropped (no rsp), and conflict_err is set.
  - conflict_err clears only on reset.
- Requests with wmem=0 and rmem=0 are accepted as no-ops.
- Read after write to the same address in consecutive cycles returns the new data, since the store completes before the read address phase.
- Reset mid-operation: a pending read is discarded, so no rsp_valid appears after rst_n deasserts. Arbitration restarts from the reset state.

Optional Feature:
- Macro: DMEM_ARB_STARVE_EN.
- When defined:
  - wait_cnt increments each cycle req1_valid = 1 and port 1 is not granted, saturating at MAX_WAIT.
  - When wait_cnt == MAX_WAIT and req1_valid = 1, port 1 is granted over port 0.
  - wait_cnt clears on any port 1 grant or when req1_valid = 0.
- When not defined: wait_cnt is absent and arbitration is strict port-0 priority. Port 1 may starve indefinitely.

Test Plan:
- Port 0 loads: port 0 writes 0xDEADBEEF to addr 0x10 with wmem=1111, then reads with rmem=01111 → rsp0_valid 1 cycle after ready, rsp0_rdata=0xDEADBEEF.
- Signed byte load: memory word 0x80FF0000 at addr 0x20, port 1 reads with rmem=11000 → rsp1_rdata=0xFFFFFF80; with rmem=00100 → 0x000000FF.
- Simultaneous requests: both ports valid in the same cycle (port 0 read addr 0x1, port 1 read addr 0x2) → req0_ready=1, req1_ready=0. Next cycle port 1 is granted and rsp0/rsp1 return on consecutive cycles with correct data.
- Starvation guard: with DMEM_ARB_STARVE_EN and MAX_WAIT=8, port 0 and port 1 are both valid continuously → req1_ready asserts on the 9th cycle, then port 0 resumes. Without the macro, req1_ready never asserts.
- Conflict: port 0 sends wmem=0011, rmem=00011, wdata=0x1234 to addr 0x5 → memory word becomes 0x00001234, no rsp0_valid, conflict_err=1 until reset.
- Reset mid-read: port 0 read accepted, then rst_n is pulled low before the next edge → rsp0_valid stays 0 after release and all outputs are 0 during reset.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port front end for the block-RAM data memory. Port 0 (LSU)
//            has priority over port 1 (DMA/loader). Tracks the one-cycle read
//            latency and steers load data back to the issuing port.
// Options  : DMEM_ARB_STARVE_EN enables the port-1 starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [3:0]  req0_wmem,
  input  logic [4:0]  req0_rmem,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  input  logic        req1_valid,
  input  logic [3:0]  req1_wmem,
  input  logic [4:0]  req1_rmem,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic [3:0]  mem_wmem,
  output logic [4:0]  mem_rmem,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_store_data,
  input  logic [31:0] mem_load_data,
  output logic        conflict_err
);

  logic        w_force1;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_any;
  logic [3:0]  w_sel_wmem;
  logic [4:0]  w_sel_rmem;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic        w_rd_issue;
  logic        w_conflict;
  logic        w_unused_addr_hi;

  logic        r_rd_pend;
  logic        r_rd_port;
  logic [4:0]  r_rmem_q;
  logic [31:0] r_addr_q;
  logic        r_conflict;

`ifdef DMEM_ARB_STARVE_EN
  logic [CNT_W-1:0] r_wait_cnt;

  assign w_force1 = req1_valid && (r_wait_cnt == CNT_W'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (!req1_valid || w_grant1) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != CNT_W'(MAX_WAIT)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] w_unused_wait_limit;

  assign w_unused_wait_limit = CNT_W'(MAX_WAIT);
  assign w_force1            = 1'b0;
`endif

  // Grants are masked while in reset so every output reads zero.
  assign w_grant0 = rst_n & req0_valid & ~w_force1;
  assign w_grant1 = rst_n & req1_valid & (~req0_valid | w_force1);
  assign w_any    = w_grant0 | w_grant1;

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  always_comb begin
    w_sel_wmem  = req0_wmem;
    w_sel_rmem  = req0_rmem;
    w_sel_addr  = {{(32-ADDR_W){1'b0}}, req0_addr[ADDR_W-1:0]};
    w_sel_wdata = req0_wdata;
    if (w_grant1) begin
      w_sel_wmem  = req1_wmem;
      w_sel_rmem  = req1_rmem;
      w_sel_addr  = {{(32-ADDR_W){1'b0}}, req1_addr[ADDR_W-1:0]};
      w_sel_wdata = req1_wdata;
    end
  end

  assign w_unused_addr_hi = ^{req0_addr[31:ADDR_W], req1_addr[31:ADDR_W]};

  // A combined store+load performs the store and drops the load.
  assign w_rd_issue = w_any && (w_sel_rmem != 5'd0) && (w_sel_wmem == 4'd0);
  assign w_conflict = w_any && (w_sel_rmem != 5'd0) && (w_sel_wmem != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend  <= 1'b0;
      r_rd_port  <= 1'b0;
      r_rmem_q   <= 5'd0;
      r_addr_q   <= 32'd0;
      r_conflict <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_issue;
      r_rmem_q  <= w_rd_issue ? w_sel_rmem : 5'd0;
      if (w_rd_issue) begin
        r_rd_port <= w_grant1;
      end
      if (w_any) begin
        r_addr_q <= w_sel_addr;
      end
      if (w_conflict) begin
        r_conflict <= 1'b1;
      end
    end
  end

  assign mem_addr       = w_any ? w_sel_addr  : r_addr_q;
  assign mem_wmem       = w_any ? w_sel_wmem  : 4'd0;
  assign mem_store_data = w_any ? w_sel_wdata : 32'd0;
  assign mem_rmem       = r_rd_pend ? r_rmem_q : 5'd0;

  assign rsp0_valid   = r_rd_pend & ~r_rd_port;
  assign rsp1_valid   = r_rd_pend &  r_rd_port;
  assign rsp0_rdata   = rsp0_valid ? mem_load_data : 32'd0;
  assign rsp1_rdata   = rsp1_valid ? mem_load_data : 32'd0;
  assign conflict_err = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// Bench for dmem_arbiter: memory model, cycle-level reference model with
// shadow memory, per-cycle compare process and directed scenarios.
module tb_dmem_arbiter;
  localparam int ADDR_W   = 15;
  localparam int MAX_WAIT = 8;
  localparam int CNT_W    = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [3:0]  req0_wmem = '0, req1_wmem = '0;
  logic [4:0]  req0_rmem = '0, req1_rmem = '0;
  logic [31:0] req0_addr = '0, req1_addr = '0, req0_wdata = '0, req1_wdata = '0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [3:0]  mem_wmem;
  logic [4:0]  mem_rmem;
  logic [31:0] mem_addr, mem_store_data, mem_load_data;
  logic        conflict_err;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_wmem(req0_wmem), .req0_rmem(req0_rmem),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_wmem(req1_wmem), .req1_rmem(req1_rmem),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_wmem(mem_wmem), .mem_rmem(mem_rmem), .mem_addr(mem_addr),
    .mem_store_data(mem_store_data), .mem_load_data(mem_load_data),
    .conflict_err(conflict_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---- byte-lane arithmetic shared by memory model and reference model ----
  function automatic int lane_lo(input logic [3:0] l);
    for (int i = 0; i < 4; i++) if (l[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [4:0] code);
    int lo, n;
    logic [31:0] v, mask;
    if (code[3:0] == 4'd0) return 32'd0;
    lo = lane_lo(code[3:0]);
    n  = $countones(code[3:0]);
    v  = word >> (8 * lo);
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = v & mask;
      if (code[4] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] lanes);
    int lo, n;
    logic [31:0] mask;
    if (lanes == 4'd0) return old;
    lo   = lane_lo(lanes);
    n    = $countones(lanes);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    return (old & ~(mask << (8 * lo))) | ((wd & mask) << (8 * lo));
  endfunction

  // ---- block-RAM model: registered read, lane select from data-phase rmem ----
  logic [31:0] mem_arr [0:DEPTH-1];
  logic [31:0] rd_word = '0;

  always @(posedge clk) begin
    if (mem_wmem != 4'd0)
      mem_arr[mem_addr[ADDR_W-1:0]] <= store_merge(mem_arr[mem_addr[ADDR_W-1:0]], mem_store_data, mem_wmem);
    rd_word <= mem_arr[mem_addr[ADDR_W-1:0]];
  end
  assign mem_load_data = load_ext(rd_word, mem_rmem);

  // ---- reference model ----
  logic [31:0] sh_arr [0:DEPTH-1];
  logic        m_pend = 1'b0, m_port = 1'b0, m_conflict = 1'b0;
  logic [4:0]  m_rmem = '0;
  logic [31:0] m_data = '0, m_addr_hold = '0;
  int          m_wait = 0;
  logic [1:0]  m_g;
  logic [3:0]  s_wmem;
  logic [4:0]  s_rmem;
  logic [31:0] s_addr, s_wdata;

  function automatic logic [1:0] exp_grant(input logic v0, input logic v1, input int waited);
    logic force1;
    force1 = 1'b0;
`ifdef DMEM_ARB_STARVE_EN
    force1 = v1 && (waited >= MAX_WAIT);
`endif
    if (force1) return 2'b10;
    if (v0) return 2'b01;
    if (v1) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    m_g     = exp_grant(req0_valid, req1_valid, m_wait);
    s_wmem  = m_g[1] ? req1_wmem : req0_wmem;
    s_rmem  = m_g[1] ? req1_rmem : req0_rmem;
    s_addr  = {17'd0, (m_g[1] ? req1_addr[ADDR_W-1:0] : req0_addr[ADDR_W-1:0])};
    s_wdata = m_g[1] ? req1_wdata : req0_wdata;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend      <= 1'b0;
      m_conflict  <= 1'b0;
      m_addr_hold <= '0;
      m_wait      <= 0;
    end else begin
      m_pend <= 1'b0;
      if (m_g != 2'b00) begin
        m_addr_hold <= s_addr;
        if (s_wmem != 4'd0)
          sh_arr[s_addr[ADDR_W-1:0]] <= store_merge(sh_arr[s_addr[ADDR_W-1:0]], s_wdata, s_wmem);
        if (s_rmem != 5'd0 && s_wmem == 4'd0) begin
          m_pend <= 1'b1;
          m_port <= m_g[1];
          m_rmem <= s_rmem;
          m_data <= load_ext(sh_arr[s_addr[ADDR_W-1:0]], s_rmem);
        end
        if (s_rmem != 5'd0 && s_wmem != 4'd0) m_conflict <= 1'b1;
      end
      if (req1_valid && !m_g[1]) m_wait <= (m_wait < MAX_WAIT) ? m_wait + 1 : m_wait;
      else m_wait <= 0;
    end
  end

  // ---- per-cycle compare ----
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_outputs_zero", {31'd0, |{req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata,
          rsp1_rdata, mem_wmem, mem_rmem, mem_addr, mem_store_data, conflict_err}}, 32'd0);
    end else begin
      chk("req0_ready", req0_ready, m_g[0]);
      chk("req1_ready", req1_ready, m_g[1]);
      chk("mem_wmem", mem_wmem, (m_g != 2'b00) ? s_wmem : 4'd0);
      chk("mem_addr", mem_addr, (m_g != 2'b00) ? s_addr : m_addr_hold);
      if (m_g != 2'b00) chk("mem_store_data", mem_store_data, s_wdata);
      chk("mem_rmem", mem_rmem, m_pend ? m_rmem : 5'd0);
      chk("rsp0_valid", rsp0_valid, m_pend && !m_port);
      chk("rsp0_rdata", rsp0_rdata, (m_pend && !m_port) ? m_data : 32'd0);
      chk("rsp1_valid", rsp1_valid, m_pend && m_port);
      chk("rsp1_rdata", rsp1_rdata, (m_pend && m_port) ? m_data : 32'd0);
      chk("conflict_err", conflict_err, m_conflict);
    end
  end

  // ---- directed stimulus ----
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [3:0] w, input logic [4:0] r,
                        input logic [31:0] a, input logic [31:0] d);
    req0_valid = v; req0_wmem = w; req0_rmem = r; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic [3:0] w, input logic [4:0] r,
                        input logic [31:0] a, input logic [31:0] d);
    req1_valid = v; req1_wmem = w; req1_rmem = r; req1_addr = a; req1_wdata = d;
  endtask

  task automatic idle();
    drive0(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
    drive1(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
  endtask

  int first_grant;
  int exp_first_grant;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_arr[i] = 32'd0;
      sh_arr[i]  = 32'd0;
    end
    #2;
    chk("init_rsp0_valid", rsp0_valid, 1'b0);
    chk("init_conflict", conflict_err, 1'b0);
    chk("init_mem_addr", mem_addr, 32'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;

    // store then load on port 0
    step();
    drive0(1'b1, 4'b1111, 5'd0, 32'h10, 32'hDEADBEEF);
    #1 chk("p0_store_ready", req0_ready, 1'b1);
    step();
    drive0(1'b1, 4'd0, 5'b01111, 32'h10, 32'd0);
    step();
    idle();
    chk("p0_load_valid", rsp0_valid, 1'b1);
    chk("p0_load_data", rsp0_rdata, 32'hDEADBEEF);
    step();
    chk("p0_load_one_shot", rsp0_valid, 1'b0);

    // signed and unsigned byte loads on port 1, back to back
    drive1(1'b1, 4'b1111, 5'd0, 32'h20, 32'h80FF0000);
    step();
    drive1(1'b1, 4'd0, 5'b11000, 32'h20, 32'd0);
    step();
    drive1(1'b1, 4'd0, 5'b00100, 32'h20, 32'd0);
    #1 chk("p1_sbyte_data", rsp1_rdata, 32'hFFFFFF80);
    chk("p1_sbyte_p0_quiet", rsp0_valid, 1'b0);
    step();
    idle();
    chk("p1_ubyte_data", rsp1_rdata, 32'h000000FF);

    // simultaneous reads
    step();
    drive0(1'b1, 4'b1111, 5'd0, 32'h1, 32'h11111111);
    step();
    drive0(1'b1, 4'b1111, 5'd0, 32'h2, 32'h22222222);
    step();
    drive0(1'b1, 4'd0, 5'b01111, 32'h1, 32'd0);
    drive1(1'b1, 4'd0, 5'b01111, 32'h2, 32'd0);
    #1 chk("sim_ready0", req0_ready, 1'b1);
    chk("sim_ready1", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    #1 chk("sim_ready1_next", req1_ready, 1'b1);
    chk("sim_rsp0_data", rsp0_rdata, 32'h11111111);
    step();
    idle();
    chk("sim_rsp1_valid", rsp1_valid, 1'b1);
    chk("sim_rsp1_data", rsp1_rdata, 32'h22222222);

    // starvation: both ports issue no-ops continuously
    step();
    drive0(1'b1, 4'd0, 5'd0, 32'h7, 32'd0);
    drive1(1'b1, 4'd0, 5'd0, 32'h8, 32'd0);
    first_grant = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      #1;
      if (req1_ready && first_grant == 0) first_grant = cyc;
      step();
    end
`ifdef DMEM_ARB_STARVE_EN
    exp_first_grant = 9;
`else
    exp_first_grant = 0;
`endif
    chk("starve_first_grant", first_grant, exp_first_grant);
    idle();

    // store+load conflict
    step();
    drive0(1'b1, 4'b0011, 5'b00011, 32'h5, 32'h1234);
    #1 chk("conf_before", conflict_err, 1'b0);
    step();
    idle();
    chk("conf_mem_word", mem_arr[5], 32'h00001234);
    chk("conf_no_rsp", rsp0_valid, 1'b0);
    chk("conf_set", conflict_err, 1'b1);
    step(); step(); step();
    chk("conf_sticky", conflict_err, 1'b1);

    // reset while a read is in flight
    drive0(1'b1, 4'd0, 5'b01111, 32'h10, 32'd0);
    step();
    idle();
    #1 rst_n = 1'b0;
    #1 chk("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk("rst_mem_rmem", mem_rmem, 5'd0);
    chk("rst_conflict", conflict_err, 1'b0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("post_rst_rsp0", rsp0_valid, 1'b0);
    chk("post_rst_conflict", conflict_err, 1'b0);

    // restart, upper address bits ignored
    drive0(1'b1, 4'd0, 5'b01111, 32'hABCD0010, 32'd0);
    #1 chk("hi_addr_masked", mem_addr, 32'h00000010);
    step();
    idle();
    chk("restart_load", rsp0_rdata, 32'hDEADBEEF);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
